// File: rtl/fetch_pkg.sv
// Shared types for the multi-issue fetch front end: buffer entries, in-flight tags and FSM state.
package fetch_pkg;

  localparam int INSN_BYTES = 4;
  // Widest PC any instance may use; narrower instances zero-extend into these fields.
  localparam int PC_W = 64;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
  } fetch_tag_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     data;
    logic            pred_taken;
    logic            fault;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, wrap-around pointers and occupancy count; head is fall-through.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multi_issue_fetch_unit.sv
// Fetch front end: issues up to MAX_OUTSTANDING pipelined requests, drops stale responses
// after a redirect, halts on a fetch fault and hands instructions to decode via a buffer.
module multi_issue_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 8,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  localparam int             CW              = $clog2(DEPTH) + 1,
  localparam int             OW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic [XLEN-1:0] bp_pc,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_pred_taken,
  output logic            inst_fault,
  output logic [CW-1:0]   buf_count,
  output logic            halted
);

  // Handshakes: a request transfers on mem_req_valid && mem_req_ready, an instruction leaves
  // on inst_valid && inst_ready; mem_req_addr stays stable while valid is held without ready.
  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_count;
  logic [OW-1:0]   out_after_rsp;

  logic            issue;
  logic            req_hs;
  logic            rsp_ok;
  logic            stale;
  logic            buf_push;
  logic [XLEN-1:0] seq_next_pc;

  fetch_tag_t      tag_in;
  fetch_tag_t      tag_out;
  logic [$bits(fetch_tag_t)-1:0] tag_rdata;
  logic            tag_full;
  logic            tag_empty;
  logic [OW-1:0]   tag_count;

  fetch_entry_t    buf_in;
  fetch_entry_t    buf_out;
  logic [$bits(fetch_entry_t)-1:0] buf_rdata;
  logic            buf_full;
  logic            buf_empty;
  logic            unused_bits;

  assign rsp_ok        = mem_rsp_valid && (outstanding != '0);
  assign stale         = (drop_count != '0);
  assign out_after_rsp = outstanding - OW'(rsp_ok);
  // Credits: every outstanding request owns a buffer slot, so a push can never overflow.
  assign issue = rst_n && (state == RUN) && !redirect_valid
              && (int'(outstanding) < MAX_OUTSTANDING)
              && ((int'(outstanding) + int'(buf_count)) < DEPTH);
  assign req_hs      = issue && mem_req_ready;
  assign buf_push    = rsp_ok && !stale && !redirect_valid;
  assign seq_next_pc = bp_taken ? {bp_target[XLEN-1:2], 2'b00} : fetch_pc + XLEN'(INSN_BYTES);

  assign mem_req_valid = issue;
  assign mem_req_addr  = fetch_pc;
  assign bp_pc         = fetch_pc;
  assign halted        = (state == HALT);

  always_comb begin
    tag_in            = '0;
    tag_in.pc         = PC_W'(fetch_pc);
    tag_in.pred_taken = bp_taken;
    buf_in            = '0;
    buf_in.pc         = tag_out.pc;
    buf_in.data       = mem_rsp_data;
    buf_in.pred_taken = tag_out.pred_taken;
    buf_in.fault      = mem_rsp_err;
  end

  assign tag_out = fetch_tag_t'(tag_rdata);
  assign buf_out = fetch_entry_t'(buf_rdata);

  fetch_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (req_hs),
    .wdata (tag_in),
    .pop   (buf_push),
    .rdata (tag_rdata),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (buf_push),
    .wdata (buf_in),
    .pop   (inst_ready && !redirect_valid),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign inst_valid      = !buf_empty;
  assign inst_pc         = buf_empty ? '0 : buf_out.pc[XLEN-1:0];
  assign inst_data       = buf_empty ? '0 : buf_out.data;
  assign inst_pred_taken = !buf_empty && buf_out.pred_taken;
  assign inst_fault      = !buf_empty && buf_out.fault;

  assign unused_bits = ^{buf_out.pc, bp_target[1:0], redirect_pc[1:0],
                         tag_full, tag_empty, tag_count, buf_full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path and is dropped on return.
      state       <= RUN;
      fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      outstanding <= out_after_rsp;
      drop_count  <= out_after_rsp;
    end else begin
      outstanding <= out_after_rsp + OW'(req_hs);
      if (rsp_ok && stale)          drop_count <= drop_count - OW'(1);
      if (req_hs)                   fetch_pc   <= seq_next_pc;
      if (buf_push && mem_rsp_err)  state      <= HALT;
    end
  end

  rsp_without_request : assert property (
    @(posedge clk) disable iff (!rst_n) mem_rsp_valid |-> (outstanding != '0));

endmodule
